// File: rtl/sti_load_sched.sv
// Serializer load scheduler: arbitrates two command requesters and paces LOAD/SHIFT/GAP.
// Define STI_SCHED_PRIO_EN for fixed priority (req0 wins ties) instead of round-robin.
module sti_load_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] cmd0_data,
  input  logic [15:0] cmd1_data,
  input  logic [4:0]  cmd0_cfg,
  input  logic [4:0]  cmd1_cfg,
  input  logic        fin_req,
  output logic        gnt0,
  output logic        gnt1,
  output logic        load,
  output logic [15:0] pi_data,
  output logic [1:0]  pi_length,
  output logic        pi_fill,
  output logic        pi_msb,
  output logic        pi_low,
  output logic        pi_end,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP, S_END} state_t;

  state_t      state;
  state_t      state_nx;
  logic [5:0]  cnt;
  logic        win1;
  logic        pick1;
  logic [5:0]  n_bits;

  assign n_bits = {({1'b0, pi_length} + 3'd1), 3'b000};

`ifdef STI_SCHED_PRIO_EN
  assign pick1 = req1 & ~req0;
`else
  logic favor1;

  // favor1 remembers who should win the next tie: the one not granted last
  assign pick1 = req1 & (~req0 | favor1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      favor1 <= 1'b0;
    else if (state == S_LOAD)
      favor1 <= ~win1;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    pi_end   = 1'b0;
    case (state)
      S_IDLE: begin
        if (req0 | req1)
          state_nx = S_LOAD;
        else if (fin_req)
          state_nx = S_END;
      end
      S_LOAD: begin
        load     = 1'b1;
        gnt0     = ~win1;
        gnt1     = win1;
        busy     = 1'b1;
        state_nx = S_SHIFT;
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (cnt == 6'd0)
          state_nx = S_GAP;
      end
      S_GAP: begin
        busy     = 1'b1;
        state_nx = S_IDLE;
      end
      S_END: begin
        done   = 1'b1;
        pi_end = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Payload is captured only when leaving IDLE, so it is stable for the whole transfer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pi_data   <= 16'd0;
      pi_length <= 2'd0;
      pi_fill   <= 1'b0;
      pi_msb    <= 1'b0;
      pi_low    <= 1'b0;
      win1      <= 1'b0;
      cnt       <= 6'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req0 | req1) begin
            win1 <= pick1;
            if (pick1) begin
              pi_data                                 <= cmd1_data;
              {pi_length, pi_fill, pi_msb, pi_low}    <= cmd1_cfg;
            end else begin
              pi_data                                 <= cmd0_data;
              {pi_length, pi_fill, pi_msb, pi_low}    <= cmd0_cfg;
            end
          end
        end
        S_LOAD:  cnt <= n_bits;
        S_SHIFT: if (cnt != 6'd0) cnt <= cnt - 6'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sti_load_sched.sv
// Self-checking bench for sti_load_sched using a transaction-timing reference model.
module tb_sti_load_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, fin_req;
  logic [15:0] cmd0_data, cmd1_data;
  logic [4:0]  cmd0_cfg, cmd1_cfg;
  logic        gnt0, gnt1, load, pi_end, busy, done;
  logic [15:0] pi_data;
  logic [1:0]  pi_length;
  logic        pi_fill, pi_msb, pi_low;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  // reference model: a transfer is described by its start offset and bit count
  bit          m_end;
  bit          m_xfer;
  int          m_k;
  int          m_n;
  bit          m_w1;
  bit          m_last1;
  logic [20:0] m_pi;

  int load_cycles[$];
  int bc;

  always #5 clk = ~clk;

  sti_load_sched dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .cmd0_data(cmd0_data), .cmd1_data(cmd1_data),
    .cmd0_cfg(cmd0_cfg), .cmd1_cfg(cmd1_cfg),
    .fin_req(fin_req),
    .gnt0(gnt0), .gnt1(gnt1), .load(load),
    .pi_data(pi_data), .pi_length(pi_length), .pi_fill(pi_fill),
    .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end),
    .busy(busy), .done(done)
  );

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  task automatic model_reset();
    m_end   = 1'b0;
    m_xfer  = 1'b0;
    m_k     = 0;
    m_n     = 0;
    m_w1    = 1'b0;
    m_last1 = 1'b1;
    m_pi    = 21'd0;
  endtask

  function automatic logic [5:0] exp_ctl();
    if (m_end)
      return 6'b000011;
    if (m_xfer && m_k == 0)
      return {~m_w1, m_w1, 4'b1100};
    if (m_xfer)
      return 6'b000100;
    return 6'b000000;
  endfunction

  // decides what the current inputs cause at the coming clock edge
  task automatic model_advance();
    if (m_end) begin
    end else if (m_xfer) begin
      m_k++;
      if (m_k == m_n + 3)
        m_xfer = 1'b0;
    end else if (req0 || req1) begin
`ifdef STI_SCHED_PRIO_EN
      m_w1 = !req0;
`else
      m_w1 = (req0 && req1) ? !m_last1 : req1;
`endif
      m_last1 = m_w1;
      m_pi    = m_w1 ? {cmd1_data, cmd1_cfg} : {cmd0_data, cmd0_cfg};
      m_n     = 8 * (int'(m_pi[4:3]) + 1);
      m_k     = 0;
      m_xfer  = 1'b1;
    end else if (fin_req) begin
      m_end = 1'b1;
    end
  endtask

  task automatic check_state(input string tag);
    check_output({tag, "_ctl"}, {26'd0, gnt0, gnt1, load, busy, done, pi_end}, {26'd0, exp_ctl()});
    check_output({tag, "_pi"}, {11'd0, pi_data, pi_length, pi_fill, pi_msb, pi_low}, {11'd0, m_pi});
  endtask

  task automatic tick(input string tag);
    model_advance();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_state(tag);
  endtask

  task automatic apply_stimulus(input bit r0, input bit r1, input logic [4:0] c0, input logic [4:0] c1);
    req0      = r0;
    req1      = r1;
    cmd0_cfg  = c0;
    cmd1_cfg  = c1;
    cmd0_data = 16'($urandom);
    cmd1_data = 16'($urandom);
  endtask

  initial begin
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; fin_req = 1'b0;
    cmd0_data = 16'd0; cmd1_data = 16'd0; cmd0_cfg = 5'd0; cmd1_cfg = 5'd0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_state("reset");
    reset = 1'b0;
    tick("idle");

    // single 16-bit command from requester 0
    req0 = 1'b1; cmd0_data = 16'hA5C3; cmd0_cfg = 5'b01010;
    tick("single_load");
    check_output("single_pi_data", {16'd0, pi_data}, 32'h0000A5C3);
    req0 = 1'b0;
    bc = 1;
    repeat (19) begin
      tick("single");
      bc += int'(busy);
    end
    check_output("single_busy_len", 32'(bc), 32'd19);

    // sustained tie with 8-bit commands
    apply_stimulus(1'b1, 1'b1, 5'b00000, 5'b00000);
    repeat (48) begin
      tick("tie");
      if (load) load_cycles.push_back(cyc);
    end
    for (int i = 1; i < load_cycles.size(); i++)
      check_output("tie_spacing", 32'(load_cycles[i] - load_cycles[i-1]), 32'd12);
    check_output("tie_count", 32'(load_cycles.size()), 32'd4);
    req0 = 1'b0; req1 = 1'b0;
    repeat (12) tick("tie_drain");

    // 32-bit then 24-bit commands
    apply_stimulus(1'b0, 1'b1, 5'b00000, 5'b11101);
    tick("len32_load");
    req1 = 1'b0;
    bc = int'(busy);
    repeat (36) begin
      tick("len32");
      bc += int'(busy);
    end
    check_output("len32_busy", 32'(bc), 32'd35);
    apply_stimulus(1'b1, 1'b0, 5'b10011, 5'b00000);
    tick("len24_load");
    req0 = 1'b0;
    bc = int'(busy);
    repeat (28) begin
      tick("len24");
      bc += int'(busy);
    end
    check_output("len24_busy", 32'(bc), 32'd27);

    // randomized traffic, including requests withdrawn before their grant
    for (int i = 0; i < 600; i++) begin
      if (!req0 && $urandom_range(3) == 0) req0 = 1'b1;
      else if (req0 && $urandom_range(15) == 0) req0 = 1'b0;
      if (!req1 && $urandom_range(3) == 0) req1 = 1'b1;
      else if (req1 && $urandom_range(15) == 0) req1 = 1'b0;
      cmd0_data = 16'($urandom); cmd1_data = 16'($urandom);
      cmd0_cfg  = 5'($urandom);  cmd1_cfg  = 5'($urandom);
      tick("rand");
      if (m_xfer && m_k == 0) begin
        if (m_w1) req1 = 1'b0;
        else      req0 = 1'b0;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (40) tick("rand_drain");

    // reset in the middle of a transfer
    apply_stimulus(1'b1, 1'b0, 5'b01000, 5'b00000);
    tick("rst_load");
    req0 = 1'b0;
    repeat (5) tick("rst_shift");
    reset = 1'b1;
    #1;
    check_output("async_rst_ctl", {26'd0, gnt0, gnt1, load, busy, done, pi_end}, 32'd0);
    check_output("async_rst_pi", {11'd0, pi_data, pi_length, pi_fill, pi_msb, pi_low}, 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_state("in_rst");
    reset = 1'b0;
    apply_stimulus(1'b0, 1'b1, 5'b00000, 5'b00000);
    tick("post_rst_load");
    check_output("post_rst_gnt1", {31'd0, gnt1}, 32'd1);
    req1 = 1'b0;
    repeat (12) tick("post_rst");
    apply_stimulus(1'b1, 1'b1, 5'b00000, 5'b00000);
    tick("post_rst_tie");
    check_output("post_rst_tie_gnt0", {30'd0, gnt0, gnt1}, 32'd2);
    req0 = 1'b0; req1 = 1'b0;
    repeat (12) tick("post_rst_drain");

    // request and end request rising together
    apply_stimulus(1'b1, 1'b0, 5'b00000, 5'b00000);
    fin_req = 1'b1;
    tick("race_load");
    req0 = 1'b0;
    repeat (15) tick("race");
    check_output("race_done", {30'd0, done, pi_end}, 32'd3);
    req1 = 1'b1;
    repeat (6) tick("end_hold");
    check_output("end_no_gnt1", {30'd0, gnt1, busy}, 32'd0);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
